imm_gen_pipe: RTL
=================

// Module: imm_gen_pipe
// PURPOSE
//   Pipelined, parametrised immediate generator for the decode stage of the pipelined core.
//   Extracts and sign-extends the immediate of each instruction and classifies its format.
//   Adds Zicsr zimm decoding and a precomputed PC-relative target for B/J/AUIPC.
//   Sits between fetch and decode, connected by valid/ready handshakes on both sides.
//   Contains a 2-entry buffer (output register + skid register), so in_ready is registered.
// PARAMETERS
//   XLEN          32  datapath width; legal values 32 or 64
//   ENABLE_ZICSR  1   1: decode CSR*I zimm; 0: every SYSTEM opcode is FMT_NONE
// PORTS
//   clk         in   1     clock, rising edge
//   rst         in   1     synchronous reset, active-high
//   flush       in   1     synchronous pipeline flush (branch redirect)
//   in_valid    in   1     instruction/PC presented
//   in_ready    out  1     stage can accept (registered)
//   in_instr    in   32    instruction word
//   in_pc       in   XLEN  instruction address
//   out_valid   out  1     out_* fields valid
//   out_ready   in   1     downstream accepts
//   out_imm     out  XLEN  extended immediate
//   out_fmt     out  3     0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z
//   out_pc      out  XLEN  pass-through PC
//   out_target  out  XLEN  in_pc + out_imm (wraps modulo 2^XLEN)
//   out_tgt_ok  out  1     1 for B, J and AUIPC only (JALR needs rs1, so 0 for JALR)
// BEHAVIOUR
//   Reset: out_valid=0, in_ready=1, skid empty, all data outputs 0.
//   Formats (opcode = instr[6:0]):
//   - I: 0010011, 0000011, 1100111, and 0011011 (XLEN=64 only)
//       imm = sext(instr[31:20])
//   - S: 0100011 -> imm = sext({instr[31:25], instr[11:7]})
//   - B: 1100011 -> imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0})
//   - U: 0110111, 0010111 -> imm = sext({instr[31:12], 12'b0}); for XLEN=64, bit 31 extends
//   - J: 1101111 -> imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0})
//   - Z: 1110011 with funct3[2]=1 and ENABLE_ZICSR=1 -> imm = zext(instr[19:15])
//   - Every other encoding -> fmt NONE, imm 0, target = pc, out_tgt_ok = 0
//   Latency: an accepted instruction appears on out_* 1 cycle later, when the output register is free.
//   Handshake: a beat transfers on valid&&ready. out_* hold stable while out_valid && !out_ready.
//   Buffering:
//   - in_ready = !skid_valid.
//   - Accept when output reg is empty or drains this cycle -> load output reg.
//   - Accept when output reg is stalled -> load skid.
//   - Output reg drains with skid full -> output reg takes skid; skid empties.
//     A simultaneous input beat is impossible, because in_ready=0.
//   - No beat is ever dropped or duplicated. Order is strictly FIFO.
//   Flush: output reg and skid are both invalid next cycle, and the input beat of that cycle is discarded.
//     Flush dominates accept/drain. Data regs may keep stale values.
//   rst mid-transfer: same as flush, and all data regs are zeroed.
//   XLEN=32 with opcode 0011011 -> NONE.
//   Parameter values outside the legal set -> elaboration error via generate check.
// TESTING
//   XLEN=32: addi 0xFFF00093 -> imm 0xFFFFFFFF, fmt I, tgt_ok 0.
//   jal 0xFFDFF06F at pc 0x100 -> imm 0xFFFFFFFC, fmt J, target 0x000000FC, tgt_ok 1.
//   beq 0x00000463 at pc 0xFFFFFFFC -> imm 8, fmt B, target 0x00000004 (wrap).
//   XLEN=64: lui 0x800000B7 -> imm 0xFFFFFFFF80000000. csrrwi 0x300FD073 -> fmt Z, imm 31.
//     With ENABLE_ZICSR=0, the same csrrwi -> fmt NONE, imm 0.
//   Back-pressure: out_ready=0 while 3 beats are offered -> 2 accepted, in_ready falls.
//     On release, the beats emerge in order with no loss.
//   flush with 2 beats buffered plus 1 offered -> out_valid=0 next cycle, in_ready=1, nothing emitted.

Source files
------------

// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle between fetch, the immediate generator and decode.
// The master side presents instructions and consumes decoded beats; the
// slave side is the immediate generator itself.
interface imm_gen_pipe_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_target;
  logic            out_tgt_ok;

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_pc, out_target, out_tgt_ok
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_pc, out_target, out_tgt_ok
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator. Extracts and sign-extends the immediate,
// classifies the instruction format and precomputes pc + imm. A two-entry
// buffer (output register plus skid register) keeps in_ready registered.
module imm_gen_pipe #(
  parameter int XLEN         = 32,
  parameter int ENABLE_ZICSR = 1
) (
  input logic          clk,
  input logic          rst,
  imm_gen_pipe_if.slave bus
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_Z    = 3'd6;

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end
  if (ENABLE_ZICSR != 0 && ENABLE_ZICSR != 1) begin : g_bad_zicsr
    $error("imm_gen_pipe: ENABLE_ZICSR must be 0 or 1");
  end

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
    logic            tgt_ok;
  } beat_t;

  logic [31:0] ins;
  logic [6:0]  opc;
  beat_t       dec;
  beat_t       out_q;
  beat_t       skid_q;
  logic        out_valid_q;
  logic        skid_valid_q;
  logic        accept;

  assign ins    = bus.in_instr;
  assign opc    = ins[6:0];
  assign accept = bus.in_valid && !skid_valid_q;

  // Combinational decode of the instruction currently offered on the input.
  always_comb begin
    dec     = '0;
    dec.fmt = FMT_NONE;
    dec.pc  = bus.in_pc;
    case (opc)
      7'b0010011, 7'b0000011, 7'b1100111: begin
        dec.fmt = FMT_I;
        dec.imm = {{(XLEN-12){ins[31]}}, ins[31:20]};
      end
      7'b0011011: begin
        // OP-IMM-32 only exists on RV64
        if (XLEN == 64) begin
          dec.fmt = FMT_I;
          dec.imm = {{(XLEN-12){ins[31]}}, ins[31:20]};
        end
      end
      7'b0100011: begin
        dec.fmt = FMT_S;
        dec.imm = {{(XLEN-12){ins[31]}}, ins[31:25], ins[11:7]};
      end
      7'b1100011: begin
        dec.fmt    = FMT_B;
        dec.tgt_ok = 1'b1;
        dec.imm    = {{(XLEN-12){ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        // bit 31 is both the top immediate bit and the extension source
        dec.fmt    = FMT_U;
        dec.tgt_ok = (opc == 7'b0010111);
        dec.imm    = {{(XLEN-31){ins[31]}}, ins[30:12], 12'h000};
      end
      7'b1101111: begin
        dec.fmt    = FMT_J;
        dec.tgt_ok = 1'b1;
        dec.imm    = {{(XLEN-20){ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      7'b1110011: begin
        if (ENABLE_ZICSR != 0 && ins[14]) begin
          dec.fmt = FMT_Z;
          dec.imm = {{(XLEN-5){1'b0}}, ins[19:15]};
        end
      end
      default: ;
    endcase
    dec.target = bus.in_pc + dec.imm;
  end

  // Output register and skid register; flush and reset empty both.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_q        <= '0;
      skid_q       <= '0;
    end else if (bus.flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (!out_valid_q || bus.out_ready) begin
      if (skid_valid_q) begin
        // in_ready is low here, so no input beat competes with the skid
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
      end else begin
        out_valid_q <= accept;
        if (accept) out_q <= dec;
      end
    end else if (accept) begin
      skid_q       <= dec;
      skid_valid_q <= 1'b1;
    end
  end

  assign bus.in_ready   = !skid_valid_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_imm    = out_q.imm;
  assign bus.out_fmt    = out_q.fmt;
  assign bus.out_pc     = out_q.pc;
  assign bus.out_target = out_q.target;
  assign bus.out_tgt_ok = out_q.tgt_ok;

endmodule
